// File: rtl/bitty_pkg.sv
// Shared definitions for the write demux and the operand select mux:
// data width, destination codes and the stage FSM encoding.
package bitty_pkg;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned NUM_DEST = 10;

  localparam logic [SEL_W-1:0] SEL_REG0 = 4'd0;
  localparam logic [SEL_W-1:0] SEL_REG1 = 4'd1;
  localparam logic [SEL_W-1:0] SEL_REG2 = 4'd2;
  localparam logic [SEL_W-1:0] SEL_REG3 = 4'd3;
  localparam logic [SEL_W-1:0] SEL_REG4 = 4'd4;
  localparam logic [SEL_W-1:0] SEL_REG5 = 4'd5;
  localparam logic [SEL_W-1:0] SEL_REG6 = 4'd6;
  localparam logic [SEL_W-1:0] SEL_REG7 = 4'd7;
  localparam logic [SEL_W-1:0] SEL_IMM  = 4'd8;
  localparam logic [SEL_W-1:0] SEL_DEF  = 4'd9;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

  // Codes above SEL_DEF address no register.
  function automatic logic sel_is_valid(input logic [SEL_W-1:0] sel);
    return sel <= SEL_DEF;
  endfunction

endpackage

// File: rtl/reg16_en.sv
// Storage register with synchronous active-high reset and write enable.
module reg16_en #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_demux.sv
// Write demux: one-entry staged write that commits into one of ten
// destination registers, stallable by freeze.
module reg_demux #(
  parameter int unsigned WIDTH = bitty_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [3:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             freeze,
  output logic [WIDTH-1:0] reg0,
  output logic [WIDTH-1:0] reg1,
  output logic [WIDTH-1:0] reg2,
  output logic [WIDTH-1:0] reg3,
  output logic [WIDTH-1:0] reg4,
  output logic [WIDTH-1:0] reg5,
  output logic [WIDTH-1:0] reg6,
  output logic [WIDTH-1:0] reg7,
  output logic [WIDTH-1:0] im_d,
  output logic [WIDTH-1:0] def_val,
  output logic [9:0]       pending,
  output logic             done,
  output logic             sel_err
);

  import bitty_pkg::*;

  stage_state_t         state;
  stage_state_t         state_nxt;
  logic [SEL_W-1:0]     stage_sel;
  logic [WIDTH-1:0]     stage_data;
  logic                 req_valid;
  logic                 accept;
  logic                 load;
  logic [NUM_DEST-1:0]  wen;
  logic [WIDTH-1:0]     q [NUM_DEST];

  assign req_valid = sel_is_valid(wr_sel);
  assign wr_ready  = !reset && (state == ST_EMPTY || !freeze);
  assign accept    = wr_valid && wr_ready;
  assign load      = accept && req_valid;
  assign done      = (state == ST_FULL) && !freeze && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (load) state_nxt = ST_FULL;
      ST_FULL:  if (!freeze) state_nxt = load ? ST_FULL : ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Stage only ever reloads when it is empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_sel  <= '0;
      stage_data <= '0;
    end else if (load) begin
      stage_sel  <= wr_sel;
      stage_data <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= accept && !req_valid;
    end
  end

  // Destination decode shared by the pending flags and the write enables.
  always_comb begin
    pending = '0;
    wen     = '0;
    for (int k = 0; k < NUM_DEST; k++) begin
      pending[k] = (state == ST_FULL) && (stage_sel == SEL_W'(k));
      wen[k]     = done && (stage_sel == SEL_W'(k));
    end
  end

  for (genvar k = 0; k < NUM_DEST; k++) begin : g_dest
    reg16_en #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .reset (reset),
      .en    (wen[k]),
      .d     (stage_data),
      .q     (q[k])
    );
  end

  assign reg0    = q[SEL_REG0];
  assign reg1    = q[SEL_REG1];
  assign reg2    = q[SEL_REG2];
  assign reg3    = q[SEL_REG3];
  assign reg4    = q[SEL_REG4];
  assign reg5    = q[SEL_REG5];
  assign reg6    = q[SEL_REG6];
  assign reg7    = q[SEL_REG7];
  assign im_d    = q[SEL_IMM];
  assign def_val = q[SEL_DEF];

endmodule

// File: tb/tb_reg_demux.sv
// Randomized bench for reg_demux against a write-queue reference model.
module tb_reg_demux;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_sel;
  logic [15:0] wr_data;
  logic        freeze;
  logic [15:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7, im_d, def_val;
  logic [9:0]  pending;
  logic        done;
  logic        sel_err;

  logic [15:0] r [10];

  int checks = 0;
  int errors = 0;

  // Reference model: architectural values plus a queue of accepted,
  // not-yet-committed writes (at most one entry by construction of the handshake).
  logic [15:0] m_regs [10];
  logic [3:0]  q_sel  [$];
  logic [15:0] q_data [$];
  logic        m_err;

  reg_demux #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_data(wr_data), .freeze(freeze),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4),
    .reg5(reg5), .reg6(reg6), .reg7(reg7), .im_d(im_d), .def_val(def_val),
    .pending(pending), .done(done), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  assign r[0] = reg0;  assign r[1] = reg1;  assign r[2] = reg2;
  assign r[3] = reg3;  assign r[4] = reg4;  assign r[5] = reg5;
  assign r[6] = reg6;  assign r[7] = reg7;  assign r[8] = im_d;
  assign r[9] = def_val;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check state.
  task automatic step(input logic rst, input logic v, input logic [3:0] sel,
                      input logic [15:0] data, input logic frz);
    logic staged, exp_ready, exp_done, acc;
    logic [9:0] exp_pend;
    @(negedge clk);
    reset = rst; wr_valid = v; wr_sel = sel; wr_data = data; freeze = frz;
    #1;
    staged    = (q_sel.size() != 0);
    exp_ready = !rst && (!staged || !frz);
    exp_done  = staged && !frz && !rst;
    exp_pend  = staged ? (10'd1 << q_sel[0]) : 10'd0;
    chk("wr_ready", 32'(wr_ready), 32'(exp_ready));
    chk("done", 32'(done), 32'(exp_done));
    chk("pending", 32'(pending), 32'(exp_pend));
    acc = v && exp_ready;
    if (rst) begin
      foreach (m_regs[k]) m_regs[k] = '0;
      q_sel.delete(); q_data.delete();
      m_err = 1'b0;
    end else begin
      if (exp_done) begin
        m_regs[q_sel[0]] = q_data[0];
        void'(q_sel.pop_front()); void'(q_data.pop_front());
      end
      m_err = acc && (sel > 4'd9);
      if (acc && sel <= 4'd9) begin
        q_sel.push_back(sel); q_data.push_back(data);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) chk($sformatf("reg_%0d", k), 32'(r[k]), 32'(m_regs[k]));
    chk("sel_err", 32'(sel_err), 32'(m_err));
  endtask

  initial begin
    foreach (m_regs[k]) m_regs[k] = '0;
    m_err = 1'b0;
    reset = 1'b1; wr_valid = 1'b0; wr_sel = '0; wr_data = '0; freeze = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
    chk("rst_pending", 32'(pending), 32'h0);

    // Single write to reg3
    step(1'b0, 1'b1, 4'b0011, 16'hBEEF, 1'b0);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    chk("d_reg3", 32'(reg3), 32'hBEEF);
    chk("d_reg0", 32'(reg0), 32'h0);

    // Back-to-back writes
    step(1'b0, 1'b1, 4'd1, 16'h1111, 1'b0);
    step(1'b0, 1'b1, 4'd1, 16'h2222, 1'b0);
    step(1'b0, 1'b1, 4'd7, 16'h0007, 1'b0);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    chk("b2b_reg1", 32'(reg1), 32'h2222);
    chk("b2b_reg7", 32'(reg7), 32'h0007);

    // Frozen stage to im_d
    step(1'b0, 1'b1, 4'b1000, 16'h00A5, 1'b0);
    repeat (3) begin
      step(1'b0, 1'b1, 4'd2, 16'h5555, 1'b1);
      chk("frz_pending", 32'(pending), 32'h100);
      chk("frz_im_d", 32'(im_d), 32'h0);
    end
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    chk("rel_im_d", 32'(im_d), 32'h00A5);
    chk("rel_reg2", 32'(reg2), 32'h0);

    // Invalid code
    step(1'b0, 1'b1, 4'b1100, 16'h1234, 1'b0);
    chk("inv_sel_err", 32'(sel_err), 32'h1);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    chk("inv_sel_err_clr", 32'(sel_err), 32'h0);

    // Staged def_val dropped by reset
    step(1'b0, 1'b1, 4'b1001, 16'hFFFF, 1'b1);
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b1);
    chk("rst_def_val", 32'(def_val), 32'h0);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    chk("rst_def_val2", 32'(def_val), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), 16'($urandom),
           ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_demux.md
REG_DEMUX -- requirements
Module: reg_demux

Interface
REQ-001 Parameter: WIDTH, 16, data width of every storage register and the write bus.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: wr_valid  input  1  write request present.
REQ-005 Port: wr_ready  output  1  block can accept a request this cycle.
REQ-006 Port: wr_sel  input  4  destination code: 0000-0111 reg0-reg7, 1000 im_d, 1001 def_val, 1010-1111 invalid.
REQ-007 Port: wr_data  input  WIDTH  value to write.
REQ-008 Port: freeze  input  1  stalls draining of the staged write.
REQ-009 Port: reg0..reg7  output  WIDTH each  architectural registers, fed to the operand select mux.
REQ-010 Port: im_d, def_val  output  WIDTH each  immediate and default-value registers.
REQ-011 Port: pending  output  10  bit k set while a staged write targets code k (bit 8 im_d, bit 9 def_val).
REQ-012 Port: done  output  1  one-cycle pulse in the cycle a staged write updates its target.
REQ-013 Port: sel_err  output  1  one-cycle pulse, registered, the cycle after an invalid-code request is accepted.

Function
REQ-014 Handshake: a request is accepted on a rising edge where wr_valid and wr_ready are both high; wr_valid/wr_sel/wr_data are don't-care otherwise.
REQ-015 A one-entry stage holds the accepted sel and data; FSM states EMPTY and FULL.
REQ-016 EMPTY -> FULL on accept of a valid code; EMPTY stays EMPTY on no accept or invalid-code accept.
REQ-017 FULL with freeze=1: stays FULL, stage contents unchanged, no register write.
REQ-018 FULL with freeze=0: target register written from stage; done=1 that cycle; next state FULL if a valid-code request is accepted the same cycle, else EMPTY.
REQ-019 wr_ready = !reset && (state==EMPTY || !freeze); back-to-back throughput one write per cycle.
REQ-020 Latency: accepted at edge N, drained with freeze=0 -> new value on target output after edge N+1.
REQ-021 Invalid codes: request accepted and discarded; no state change other than sel_err=1 after that edge.
REQ-022 Writes to the same target commit strictly in acceptance order; the later value wins.
REQ-023 pending is one-hot on the staged code when FULL and all-zero when EMPTY; combinational from stage state.
REQ-024 done is combinational: (state==FULL && !freeze && !reset).
REQ-025 Outputs not targeted hold their values; only the one selected register changes per commit.
REQ-026 No arithmetic; data passes bit-exact, WIDTH bits, no extension or truncation.

Reset
REQ-027 With reset high at an edge: reg0-reg7, im_d and def_val become 0, state becomes EMPTY, sel_err becomes 0.
REQ-028 A staged write present when reset asserts is dropped, never committed; wr_ready, done are 0 while reset is high.
REQ-029 reset has priority over freeze, accept and commit in the same cycle.

Structure
REQ-030 Shared package bitty_pkg holds WIDTH and the ten destination codes (SEL_REG0..SEL_REG7, SEL_IMM, SEL_DEF), shared with the operand select mux.
REQ-031 One sub-module reg16_en: WIDTH-bit register with synchronous active-high reset and write enable, instantiated ten times.
REQ-032 FSM, stage register, decode and pending logic stay in reg_demux.

Verification
REQ-033 Reset then write sel=0011 data=0xBEEF, freeze=0 -> done pulse at next edge, reg3=0xBEEF, all others 0.
REQ-034 Back-to-back writes reg1=0x1111, reg1=0x2222, reg7=0x0007 on consecutive cycles -> wr_ready stays 1, final reg1=0x2222, reg7=0x0007.
REQ-035 Stage write sel=1000 data=0x00A5, hold freeze=1 for 3 cycles -> pending=10'b01_0000_0000, wr_ready=0, im_d unchanged; release -> im_d=0x00A5, done pulse.
REQ-036 Request sel=1100 -> accepted, sel_err pulse one cycle later, pending=0, no register changes, no done.
REQ-037 Stage sel=1001 data=0xFFFF with freeze=1, assert reset -> def_val=0, state EMPTY, no done pulse.
